// File: rtl/mlaccel_qpi_pkg.sv
// -----------------------------------------------------------------------------
// mlaccel_qpi_pkg
// Shared definitions for the QPI slave bridge: command opcodes, the transfer
// state machine encoding and the 16-bit bus address type.
// Optional feature macro (used by mlaccel_qpi): MLACCEL_QPI_ERR_EN
// -----------------------------------------------------------------------------
package mlaccel_qpi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h21;
    localparam logic [7:0] CMD_READ  = 8'h22;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        WDATA,
        RDUMMY,
        RDATA,
        IGNORE
    } state_t;

    typedef logic [15:0] addr_t;

endpackage

// File: rtl/mlaccel_qpi_sync.sv
// -----------------------------------------------------------------------------
// mlaccel_qpi_sync
// Brings the asynchronous QPI pad signals into the system clock domain and
// detects edges on the synchronized chip select and serial clock.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   csb_i, clk_i, di_i  raw pad inputs
//   csb_sync            synchronized chip select level
//   csb_fall/csb_rise   one-cycle pulses on synchronized csb edges
//   clk_rise/clk_fall   one-cycle pulses on synchronized serial clock edges
//   di_sync             data nibble, delayed identically to clk so it is
//                       aligned with clk_rise
// -----------------------------------------------------------------------------
module mlaccel_qpi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       csb_i,
    input  logic       clk_i,
    input  logic [3:0] di_i,
    output logic       csb_sync,
    output logic       csb_fall,
    output logic       csb_rise,
    output logic       clk_rise,
    output logic       clk_fall,
    output logic [3:0] di_sync
);

    // Each stage carries {csb, clk, di[3:0]} so all three see equal latency.
    localparam logic [5:0] STAGE_RST = 6'b11_0000;

    logic [5:0] stage_q [SYNC_STAGES];
    logic       csb_prev_q;
    logic       clk_prev_q;
    logic       clk_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= STAGE_RST;
            end
            csb_prev_q <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            stage_q[0] <= {csb_i, clk_i, di_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            csb_prev_q <= csb_sync;
            clk_prev_q <= clk_sync;
        end
    end

    assign csb_sync = stage_q[SYNC_STAGES-1][5];
    assign clk_sync = stage_q[SYNC_STAGES-1][4];
    assign di_sync  = stage_q[SYNC_STAGES-1][3:0];

    assign csb_fall = csb_prev_q & ~csb_sync;
    assign csb_rise = ~csb_prev_q & csb_sync;
    assign clk_rise = ~clk_prev_q & clk_sync;
    assign clk_fall = clk_prev_q & ~clk_sync;

endmodule

// File: rtl/mlaccel_qpi.sv
// -----------------------------------------------------------------------------
// mlaccel_qpi
// Quad-SPI (4-bit) slave that converts host transactions into a simple
// byte-wide memory bus. Command 0x21 writes bytes from a 16-bit address,
// command 0x22 reads with one dummy byte; addresses auto-increment and wrap.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   qpi_csb/clk/di       host chip select (low active), serial clock, data in
//   qpi_do, qpi_oe       pad output nibble and its output enable
//   qpi_rdy              idle and chip select deasserted
//   qpi_err              protocol error flag (sticky until next csb fall)
//   wr_en/addr/data      one-cycle write strobe with address and byte
//   rd_en/addr, rd_data  one-cycle read strobe; rd_data valid next cycle
//
// Optional feature macro: MLACCEL_QPI_ERR_EN enables protocol error
// detection; without it qpi_err is tied low.
// -----------------------------------------------------------------------------
module mlaccel_qpi
    import mlaccel_qpi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        qpi_csb,
    input  logic        qpi_clk,
    input  logic [3:0]  qpi_di,
    output logic [3:0]  qpi_do,
    output logic        qpi_oe,
    output logic        qpi_rdy,
    output logic        qpi_err,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data
);

    logic       csb_sync;
    logic       csb_fall;
    logic       csb_rise;
    logic       clk_rise;
    logic       clk_fall;
    logic [3:0] di_sync;

    mlaccel_qpi_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .csb_i    (qpi_csb),
        .clk_i    (qpi_clk),
        .di_i     (qpi_di),
        .csb_sync (csb_sync),
        .csb_fall (csb_fall),
        .csb_rise (csb_rise),
        .clk_rise (clk_rise),
        .clk_fall (clk_fall),
        .di_sync  (di_sync)
    );

    state_t     state_q;
    logic       nib_q;      // 1 once the high nibble of a byte is held
    logic       phase_q;    // 1 once the high nibble of an outgoing byte is driven
    logic [3:0] hi_q;
    logic [7:0] cmd_q;
    addr_t      addr_q;
    logic [7:0] tx_q;
    logic [7:0] pre_q;      // prefetched read byte
    logic       pend_q;     // rd_data is valid this cycle
    logic [3:0] do_q;
    logic       oe_q;
    logic       rdy_q;
    logic       wr_en_q;
    addr_t      wr_addr_q;
    logic [7:0] wr_data_q;
    logic       rd_en_q;
    addr_t      rd_addr_q;
    logic [7:0] byte_d;

    assign byte_d = {hi_q, di_sync};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            nib_q     <= 1'b0;
            phase_q   <= 1'b0;
            hi_q      <= 4'h0;
            cmd_q     <= 8'h00;
            addr_q    <= 16'h0000;
            tx_q      <= 8'h00;
            pre_q     <= 8'h00;
            pend_q    <= 1'b0;
            do_q      <= 4'h0;
            oe_q      <= 1'b0;
            rdy_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 16'h0000;
            wr_data_q <= 8'h00;
            rd_en_q   <= 1'b0;
            rd_addr_q <= 16'h0000;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            pend_q  <= rd_en_q;
            if (pend_q) begin
                pre_q <= rd_data;
            end
            rdy_q <= (state_q == IDLE) && csb_sync;

            if (csb_rise) begin
                // Abort whatever is in flight: partial bytes and any
                // outstanding prefetch are simply dropped.
                state_q <= IDLE;
                nib_q   <= 1'b0;
                phase_q <= 1'b0;
                pend_q  <= 1'b0;
                oe_q    <= 1'b0;
                do_q    <= 4'h0;
            end else if (csb_fall) begin
                state_q <= CMD;
                nib_q   <= 1'b0;
                phase_q <= 1'b0;
                pend_q  <= 1'b0;
                oe_q    <= 1'b0;
                do_q    <= 4'h0;
            end else if (state_q != IDLE) begin
                if (clk_rise) begin
                    nib_q <= ~nib_q;
                    if (!nib_q) begin
                        hi_q <= di_sync;
                    end else begin
                        case (state_q)
                            CMD: begin
                                cmd_q   <= byte_d;
                                state_q <= (byte_d == CMD_WRITE || byte_d == CMD_READ)
                                           ? ADDR_HI : IGNORE;
                            end
                            ADDR_HI: begin
                                addr_q[15:8] <= byte_d;
                                state_q      <= ADDR_LO;
                            end
                            ADDR_LO: begin
                                addr_q[7:0] <= byte_d;
                                if (cmd_q == CMD_READ) begin
                                    // Prefetch the first byte during the dummy cycle.
                                    rd_en_q   <= 1'b1;
                                    rd_addr_q <= {addr_q[15:8], byte_d};
                                    phase_q   <= 1'b0;
                                    state_q   <= RDUMMY;
                                end else begin
                                    state_q <= WDATA;
                                end
                            end
                            WDATA: begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= byte_d;
                                addr_q    <= addr_q + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                end

                if (clk_fall) begin
                    case (state_q)
                        RDUMMY: begin
                            oe_q    <= 1'b1;
                            do_q    <= 4'h0;
                            phase_q <= ~phase_q;
                            if (phase_q) begin
                                state_q <= RDATA;
                            end
                        end
                        RDATA: begin
                            phase_q <= ~phase_q;
                            if (!phase_q) begin
                                // Start of a byte: ship the prefetched value and
                                // immediately fetch the following address.
                                tx_q      <= pre_q;
                                do_q      <= pre_q[7:4];
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= addr_q + 16'd1;
                                addr_q    <= addr_q + 16'd1;
                            end else begin
                                do_q <= tx_q[3:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef MLACCEL_QPI_ERR_EN
    logic err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (csb_fall) begin
            err_q <= 1'b0;
        end else if (csb_rise) begin
            if (state_q != IDLE && nib_q) begin
                err_q <= 1'b1;
            end
        end else if (state_q == CMD && clk_rise && nib_q &&
                     byte_d != CMD_WRITE && byte_d != CMD_READ) begin
            err_q <= 1'b1;
        end
    end

    assign qpi_err = err_q;
`else
    assign qpi_err = 1'b0;
`endif

    assign qpi_do  = do_q;
    assign qpi_oe  = oe_q;
    assign qpi_rdy = rdy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_mlaccel_qpi.sv
// -----------------------------------------------------------------------------
// tb_mlaccel_qpi
// Drives QPI host transactions into mlaccel_qpi, models the attached byte
// memory, and compares strobes and read data against expected values derived
// from the transaction-level behaviour (address auto-increment modulo 2^16,
// one dummy byte before read data).
// -----------------------------------------------------------------------------
module tb_mlaccel_qpi;

`ifdef MLACCEL_QPI_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int HP = 8;   // host half period in system clocks

    logic        clock;
    logic        reset;
    logic        qpi_csb;
    logic        qpi_clk;
    logic [3:0]  qpi_di;
    logic [3:0]  qpi_do;
    logic        qpi_oe;
    logic        qpi_rdy;
    logic        qpi_err;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;

    mlaccel_qpi #(
        .SYNC_STAGES (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .qpi_csb (qpi_csb),
        .qpi_clk (qpi_clk),
        .qpi_di  (qpi_di),
        .qpi_do  (qpi_do),
        .qpi_oe  (qpi_oe),
        .qpi_rdy (qpi_rdy),
        .qpi_err (qpi_err),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: written only by the stimulus process (it is also the
    // reference shadow), read by the bus responder below.
    logic [7:0] mem [0:65535];

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wr_log [$];
    int  rd_cnt     = 0;
    bit  both_seen  = 1'b0;

    always @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_cnt  <= rd_cnt + 1;
        end
        if (wr_en) begin
            wr_log.push_back({wr_addr, wr_data});
        end
        if (wr_en && rd_en) begin
            both_seen <= 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic csb_low();
        qpi_csb = 1'b0;
        wait_clk(HP);
    endtask

    task automatic csb_high();
        qpi_clk = 1'b1;
        qpi_csb = 1'b1;
        wait_clk(2 * HP);
    endtask

    task automatic send_nib(input logic [3:0] n);
        qpi_clk = 1'b0;
        qpi_di  = n;
        wait_clk(HP);
        qpi_clk = 1'b1;
        wait_clk(HP);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic read_byte(output logic [7:0] b);
        qpi_clk = 1'b0;
        wait_clk(HP);
        b[7:4]  = qpi_do;
        qpi_clk = 1'b1;
        wait_clk(HP);
        qpi_clk = 1'b0;
        wait_clk(HP);
        b[3:0]  = qpi_do;
        qpi_clk = 1'b1;
        wait_clk(HP);
    endtask

    logic [7:0] wdata [0:15];

    // Write wdata[0..n-1] starting at a, then compare logged strobes.
    task automatic do_write(input logic [15:0] a, input int n);
        int          base;
        logic [15:0] ea;
        base = wr_log.size();
        csb_low();
        send_byte(8'h21);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        for (int i = 0; i < n; i++) begin
            send_byte(wdata[i]);
        end
        csb_high();
        $display("write addr=%04h len=%0d strobes=%0d", a, n, wr_log.size() - base);
        check_val("wr_cnt", 32'(wr_log.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            ea = a + 16'(i);
            if (base + i < wr_log.size()) begin
                check_val("wr_addr", 32'(wr_log[base+i].a), 32'(ea));
                check_val("wr_data", 32'(wr_log[base+i].d), 32'(wdata[i]));
            end
            mem[ea] = wdata[i];
        end
    endtask

    // Read n bytes from a: byte 0 is the dummy, byte k is mem[a+k-1].
    task automatic do_read(input logic [15:0] a, input int n);
        logic [7:0]  b;
        logic [7:0]  exp;
        logic [15:0] ea;
        csb_low();
        send_byte(8'h22);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        for (int k = 0; k < n; k++) begin
            read_byte(b);
            ea  = a + 16'(k) - 16'd1;
            exp = (k == 0) ? 8'h00 : mem[ea];
            check_val("rd_byte", 32'(b), 32'(exp));
            if (k == 0) begin
                check_val("oe_on", 32'(qpi_oe), 32'd1);
            end
        end
        csb_high();
        $display("read  addr=%04h len=%0d", a, n);
        check_val("oe_off", 32'(qpi_oe), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] ra;
    int          rn;
    int          wr_before;
    int          rd_before;
    logic [7:0]  rb;

    initial begin
        reset   = 1'b1;
        qpi_csb = 1'b1;
        qpi_clk = 1'b1;
        qpi_di  = 4'h0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
        end

        // Reset state
        wait_clk(4);
        check_val("rst_do",  32'(qpi_do),  32'd0);
        check_val("rst_oe",  32'(qpi_oe),  32'd0);
        check_val("rst_rdy", 32'(qpi_rdy), 32'd0);
        check_val("rst_err", 32'(qpi_err), 32'd0);
        check_val("rst_wr",  32'(wr_en),   32'd0);
        check_val("rst_rd",  32'(rd_en),   32'd0);
        reset = 1'b0;
        wait_clk(2 * HP);
        check_val("idle_rdy", 32'(qpi_rdy), 32'd1);

        // Directed write burst
        for (int i = 0; i < 12; i++) begin
            wdata[i] = 8'(i + 1);
        end
        do_write(16'h0110, 12);
        check_val("err_clean", 32'(qpi_err), 32'd0);

        // Directed read burst
        for (int i = 0; i < 20; i++) begin
            mem[16'h0310 + 16'(i)] = 8'(i + 8'h40);
        end
        do_read(16'h0310, 20);

        // Address wrap
        wdata[0] = 8'hAA;
        wdata[1] = 8'hBB;
        do_write(16'hFFFF, 2);

        // Abort after a partial byte
        wr_before = wr_log.size();
        csb_low();
        send_byte(8'h21);
        send_byte(8'h01);
        send_nib(4'h5);
        csb_high();
        $display("abort after 5 nibbles");
        check_val("abort_wr",  32'(wr_log.size() - wr_before), 32'd0);
        check_val("abort_rdy", 32'(qpi_rdy), 32'd1);
        check_val("abort_err", 32'(qpi_err), 32'(ERR_EN));

        // Unknown command
        wr_before = wr_log.size();
        rd_before = rd_cnt;
        csb_low();
        send_byte(8'h7E);
        send_byte(8'h12);
        send_byte(8'h34);
        check_val("unk_oe", 32'(qpi_oe), 32'd0);
        csb_high();
        $display("unknown command 7E");
        check_val("unk_wr",  32'(wr_log.size() - wr_before), 32'd0);
        check_val("unk_rd",  32'(rd_cnt - rd_before), 32'd0);
        check_val("unk_err", 32'(qpi_err), 32'(ERR_EN));

        // Randomized write-then-read-back, biased toward the wrap boundary
        for (int it = 0; it < 8; it++) begin
            ra = 16'($urandom);
            if (it % 3 == 0) begin
                ra = 16'hFFFF - 16'($urandom_range(0, 3));
            end
            rn = int'($urandom_range(1, 6));
            for (int i = 0; i < rn; i++) begin
                wdata[i] = 8'($urandom);
            end
            do_write(ra, rn);
            do_read(ra - 16'($urandom_range(0, 1)), rn + 2);
        end
        check_val("err_rand", 32'(qpi_err), 32'd0);

        // Reset during the 5th read byte
        csb_low();
        send_byte(8'h22);
        send_byte(8'h03);
        send_byte(8'h10);
        for (int k = 0; k < 4; k++) begin
            read_byte(rb);
            check_val("pre_rst_byte", 32'(rb), 32'((k == 0) ? 8'h00 : mem[16'h0310 + 16'(k) - 16'd1]));
        end
        qpi_clk = 1'b0;
        wait_clk(HP / 2);
        reset = 1'b1;
        @(negedge clock);
        $display("reset asserted mid-read");
        check_val("rst_oe_mid", 32'(qpi_oe), 32'd0);
        check_val("rst_rd_mid", 32'(rd_en), 32'd0);
        qpi_csb = 1'b1;
        qpi_clk = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        rd_before = rd_cnt;
        wr_before = wr_log.size();
        wait_clk(2 * HP);
        check_val("post_rst_rd",  32'(rd_cnt - rd_before), 32'd0);
        check_val("post_rst_wr",  32'(wr_log.size() - wr_before), 32'd0);
        check_val("post_rst_rdy", 32'(qpi_rdy), 32'd1);
        do_read(16'h0310, 6);

        check_val("wr_rd_excl", 32'(both_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
